gpio_controller: RTL and testbench
==================================

// Module: gpio_controller
// PURPOSE
//   Parametrised memory-mapped GPIO controller on the CPU data bus. Adds atomic
//   set/clear/toggle writes, per-pin rising/falling edge detection with sticky
//   W1C status, and a level interrupt to the core. Sits beside other bus
//   peripherals and drives FPGA pins through per-pin tristates.
// PARAMETERS
//   WIDTH      16      number of GPIO pins, 1..BUS_W
//   BUS_W      16      data bus width; register bits >= WIDTH read 0, ignore writes
//   BASE_ADDR  32'h4034  byte address of register offset 0x00
//   SYNC_DEPTH 3       input synchronizer flop stages, >= 2
// PORTS
//   clk             in     1      system clock
//   reset           in     1      synchronous, active-high reset
//   data_bus_write  in     BUS_W  write data
//   data_bus_read   out    BUS_W  read data, combinational from addr
//   data_bus_addr   in     32     byte address
//   data_bus_mode   in     2      00 idle, 01 read, 10 write, 11 ignored
//   data_bus_select in     1      peripheral select
//   gpio_pins       inout  WIDTH  physical pins
//   irq             out    1      level interrupt = |(IRQ_STATUS & IRQ_EN)
// BEHAVIOUR
//   Register map (offset from BASE_ADDR, exact 32-bit compare):
//     00 DIR rw (1=output) | 04 OUT rw | 08 IN ro | 0C OUT_SET wo | 10 OUT_CLR wo
//     14 OUT_TGL wo | 18 IRQ_EN rw | 1C IRQ_RISE rw | 20 IRQ_FALL rw | 24 IRQ_STATUS rw1c
//   - Write strobe: mode==10 && select && addr mapped; takes effect next clk edge.
//   - OUT_SET: OUT|=d; OUT_CLR: OUT&=~d; OUT_TGL: OUT^=d. Write-only regs read 0.
//   - Unmapped addr: reads 0, writes dropped. Read mux independent of mode/select.
//   - Pin i driven with OUT[i] when DIR[i]=1, else Z; DIR/OUT change visible on
//     pins the cycle after the write edge.
//   - Input path: pins -> SYNC_DEPTH flops -> IN register. Pin change at edge t
//     appears in IN at edge t+SYNC_DEPTH+1. Output pins also read back via IN.
//   - Edge detect compares synchronizer output s with IN: rise=s&~IN,
//     fall=~s&IN; STATUS |= (rise&IRQ_RISE)|(fall&IRQ_FALL) on same edge IN
//     updates. Applies regardless of DIR.
//   - STATUS write: bits with d=1 cleared. Same-cycle clear and new edge on a
//     bit -> bit stays 1 (set wins).
//   - irq combinational from STATUS/IRQ_EN flops: asserts same cycle STATUS
//     bit sets; deasserts cycle after W1C or IRQ_EN clear. Masked status kept.
//   - Reset (sync, any time incl. mid-edge): DIR, OUT, IN, IRQ_EN, IRQ_RISE,
//     IRQ_FALL, STATUS, sync flops = 0; pins Z; irq=0; no edge reported on
//     first cycle after reset since IN and sync both 0.
// STRUCTURE
//   - gpio_pkg: register offset localparams, bus mode encodings (MODE_IDLE/READ/WRITE).
//   - Sub-module gpio_input_sync: WIDTH x SYNC_DEPTH flop chain, sync
//     active-high reset. Top holds regs, decode, edge logic, tristates.
// TESTING
//   1 Reset: hold reset 2 cycles -> all regs read 0, pins all Z, irq=0.
//   2 DIR=0x00FF, OUT=0xA5A5 -> pins[7:0]=0xA5, pins[15:8]=Z; OUT_SET 0x0002,
//     OUT_CLR 0x0001, OUT_TGL 0x0080 -> OUT reads 0xA526, pins[7:0]=0x26.
//   3 IRQ_RISE=IRQ_EN=0x0008; drive pin3 0->1 at edge t -> IN[3]=1 and
//     STATUS=0x0008, irq=1 at edge t+4 (SYNC_DEPTH=3); falling edge -> no change.
//   4 STATUS W1C 0x0008 -> irq 0 next cycle; W1C coinciding with new rise on
//     pin3 -> STATUS[3] stays 1, irq stays 1.
//   5 Write 0xFFFF to offset 0x28, to DIR with select=0, and with mode=11 ->
//     no register changes; read 0x28 -> 0; read OUT_SET -> 0.
//   6 With DIR=0xFFFF, STATUS!=0, irq=1, assert reset one cycle mid-edge ->
//     next edge all regs 0, pins Z, irq 0, no spurious STATUS bits after release.

Source files
------------

// File: rtl/gpio_pkg.sv
// Purpose: shared constants for the GPIO controller: register offsets, bus
// mode encodings, register-select enum and the address decode helper.
// Ports: none (package).
package gpio_pkg;

    localparam logic [31:0] OFF_DIR        = 32'h00;
    localparam logic [31:0] OFF_OUT        = 32'h04;
    localparam logic [31:0] OFF_IN         = 32'h08;
    localparam logic [31:0] OFF_OUT_SET    = 32'h0C;
    localparam logic [31:0] OFF_OUT_CLR    = 32'h10;
    localparam logic [31:0] OFF_OUT_TGL    = 32'h14;
    localparam logic [31:0] OFF_IRQ_EN     = 32'h18;
    localparam logic [31:0] OFF_IRQ_RISE   = 32'h1C;
    localparam logic [31:0] OFF_IRQ_FALL   = 32'h20;
    localparam logic [31:0] OFF_IRQ_STATUS = 32'h24;

    localparam logic [1:0] MODE_IDLE  = 2'b00;
    localparam logic [1:0] MODE_READ  = 2'b01;
    localparam logic [1:0] MODE_WRITE = 2'b10;

    typedef enum logic [3:0] {
        REG_DIR,
        REG_OUT,
        REG_IN,
        REG_OUT_SET,
        REG_OUT_CLR,
        REG_OUT_TGL,
        REG_IRQ_EN,
        REG_IRQ_RISE,
        REG_IRQ_FALL,
        REG_IRQ_STATUS,
        REG_NONE
    } reg_sel_e;

    // Exact 32-bit match: addr - base wraps modulo 2^32, so only base+offset hits.
    function automatic reg_sel_e decode_addr(input logic [31:0] addr,
                                             input logic [31:0] base);
        logic [31:0] off;
        off = addr - base;
        case (off)
            OFF_DIR:        decode_addr = REG_DIR;
            OFF_OUT:        decode_addr = REG_OUT;
            OFF_IN:         decode_addr = REG_IN;
            OFF_OUT_SET:    decode_addr = REG_OUT_SET;
            OFF_OUT_CLR:    decode_addr = REG_OUT_CLR;
            OFF_OUT_TGL:    decode_addr = REG_OUT_TGL;
            OFF_IRQ_EN:     decode_addr = REG_IRQ_EN;
            OFF_IRQ_RISE:   decode_addr = REG_IRQ_RISE;
            OFF_IRQ_FALL:   decode_addr = REG_IRQ_FALL;
            OFF_IRQ_STATUS: decode_addr = REG_IRQ_STATUS;
            default:        decode_addr = REG_NONE;
        endcase
    endfunction

endpackage

// File: rtl/gpio_input_sync.sv
// Purpose: WIDTH-bit, SYNC_DEPTH-stage synchronizer for the asynchronous pins.
// Ports:
//   i_clk    in   1      clock
//   i_reset  in   1      synchronous active-high reset, clears every stage
//   i_async  in   WIDTH  raw pin values
//   o_sync   out  WIDTH  last synchronizer stage
module gpio_input_sync
    import gpio_pkg::*;
#(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned SYNC_DEPTH = 3
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_sync
);

    logic [WIDTH-1:0] r_chain [SYNC_DEPTH];

    // Shift chain; stage 0 samples the pins.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int k = 0; k < int'(SYNC_DEPTH); k++) begin
                r_chain[k] <= '0;
            end
        end else begin
            r_chain[0] <= i_async;
            for (int k = 1; k < int'(SYNC_DEPTH); k++) begin
                r_chain[k] <= r_chain[k-1];
            end
        end
    end

    assign o_sync = r_chain[SYNC_DEPTH-1];

endmodule

// File: rtl/gpio_controller.sv
// Purpose: memory-mapped GPIO block with atomic set/clear/toggle, per-pin
// edge detection into sticky W1C status, and a level interrupt.
// Ports:
//   clk              in     1      system clock
//   reset            in     1      synchronous active-high reset
//   data_bus_write   in     BUS_W  write data
//   data_bus_read    out    BUS_W  read data, combinational from address
//   data_bus_addr    in     32     byte address
//   data_bus_mode    in     2      00 idle, 01 read, 10 write, 11 ignored
//   data_bus_select  in     1      peripheral select
//   gpio_pins        inout  WIDTH  physical pins (driven when DIR=1)
//   irq              out    1      |(IRQ_STATUS & IRQ_EN)
module gpio_controller
    import gpio_pkg::*;
#(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned BUS_W      = 16,
    parameter logic [31:0] BASE_ADDR  = 32'h4034,
    parameter int unsigned SYNC_DEPTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [BUS_W-1:0] data_bus_write,
    output logic [BUS_W-1:0] data_bus_read,
    input  logic [31:0]      data_bus_addr,
    input  logic [1:0]       data_bus_mode,
    input  logic             data_bus_select,
    inout  wire  [WIDTH-1:0] gpio_pins,
    output logic             irq
);

    logic [WIDTH-1:0] r_dir;
    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] r_in;
    logic [WIDTH-1:0] r_irq_en;
    logic [WIDTH-1:0] r_irq_rise;
    logic [WIDTH-1:0] r_irq_fall;
    logic [WIDTH-1:0] r_status;

    reg_sel_e         w_sel;
    logic             w_wr;
    logic [WIDTH-1:0] w_wdata;
    logic [WIDTH-1:0] w_sync;
    logic [WIDTH-1:0] w_events;
    logic [WIDTH-1:0] w_clr;
    logic [WIDTH-1:0] w_rdata;

    gpio_input_sync #(
        .WIDTH      (WIDTH),
        .SYNC_DEPTH (SYNC_DEPTH)
    ) u_sync (
        .i_clk   (clk),
        .i_reset (reset),
        .i_async (gpio_pins),
        .o_sync  (w_sync)
    );

    assign w_sel   = decode_addr(data_bus_addr, BASE_ADDR);
    assign w_wr    = (data_bus_mode == MODE_WRITE) && data_bus_select && (w_sel != REG_NONE);
    assign w_wdata = data_bus_write[WIDTH-1:0];

    // Edges are seen between the synchronizer output and IN, independent of DIR.
    assign w_events = ((w_sync & ~r_in) & r_irq_rise) | ((~w_sync & r_in) & r_irq_fall);
    assign w_clr    = (w_wr && (w_sel == REG_IRQ_STATUS)) ? w_wdata : '0;

    // Register file; new events are OR-ed after the clear so a set wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_dir      <= '0;
            r_out      <= '0;
            r_in       <= '0;
            r_irq_en   <= '0;
            r_irq_rise <= '0;
            r_irq_fall <= '0;
            r_status   <= '0;
        end else begin
            r_in     <= w_sync;
            r_status <= (r_status & ~w_clr) | w_events;
            if (w_wr) begin
                case (w_sel)
                    REG_DIR:      r_dir      <= w_wdata;
                    REG_OUT:      r_out      <= w_wdata;
                    REG_OUT_SET:  r_out      <= r_out | w_wdata;
                    REG_OUT_CLR:  r_out      <= r_out & ~w_wdata;
                    REG_OUT_TGL:  r_out      <= r_out ^ w_wdata;
                    REG_IRQ_EN:   r_irq_en   <= w_wdata;
                    REG_IRQ_RISE: r_irq_rise <= w_wdata;
                    REG_IRQ_FALL: r_irq_fall <= w_wdata;
                    default: ;
                endcase
            end
        end
    end

    // Read mux ignores mode/select; write-only and unmapped offsets read 0.
    always_comb begin
        w_rdata = '0;
        case (w_sel)
            REG_DIR:        w_rdata = r_dir;
            REG_OUT:        w_rdata = r_out;
            REG_IN:         w_rdata = r_in;
            REG_IRQ_EN:     w_rdata = r_irq_en;
            REG_IRQ_RISE:   w_rdata = r_irq_rise;
            REG_IRQ_FALL:   w_rdata = r_irq_fall;
            REG_IRQ_STATUS: w_rdata = r_status;
            default: ;
        endcase
    end

    assign data_bus_read = BUS_W'(w_rdata);
    assign irq           = |(r_status & r_irq_en);

    // Per-pin tristate driver.
    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_pin
        assign gpio_pins[i] = r_dir[i] ? r_out[i] : 1'bz;
    end

endmodule

// File: tb/tb_gpio_controller.sv
// Purpose: directed self-checking bench for gpio_controller (default params).
module tb_gpio_controller;
    import gpio_pkg::*;

    localparam logic [31:0] BASE = 32'h4034;

    logic        clk;
    logic        reset;
    logic [15:0] data_bus_write;
    logic [15:0] data_bus_read;
    logic [31:0] data_bus_addr;
    logic [1:0]  data_bus_mode;
    logic        data_bus_select;
    wire  [15:0] gpio_pins;
    logic        irq;

    logic [15:0] tb_en;
    logic [15:0] tb_val;

    int n_vec;
    int n_miscmp;

    gpio_controller #(
        .WIDTH      (16),
        .BUS_W      (16),
        .BASE_ADDR  (BASE),
        .SYNC_DEPTH (3)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .data_bus_write  (data_bus_write),
        .data_bus_read   (data_bus_read),
        .data_bus_addr   (data_bus_addr),
        .data_bus_mode   (data_bus_mode),
        .data_bus_select (data_bus_select),
        .gpio_pins       (gpio_pins),
        .irq             (irq)
    );

    // External pin drivers standing in for the board.
    for (genvar i = 0; i < 16; i++) begin : g_ext
        assign gpio_pins[i] = tb_en[i] ? tb_val[i] : 1'bz;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [15:0] d,
                      input logic [1:0] m, input logic s);
        data_bus_addr   = a;
        data_bus_write  = d;
        data_bus_mode   = m;
        data_bus_select = s;
        @(posedge clk);
        #1;
        data_bus_mode   = MODE_IDLE;
        data_bus_select = 1'b0;
    endtask

    task automatic wrw(input logic [31:0] a, input logic [15:0] d);
        wr(a, d, MODE_WRITE, 1'b1);
    endtask

    task automatic rd(input logic [31:0] a, output logic [15:0] d);
        data_bus_addr = a;
        @(negedge clk);
        d = data_bus_read;
        @(posedge clk);
        #1;
    endtask

    task automatic peek(input logic [31:0] a, output logic [15:0] d);
        data_bus_addr = a;
        #1;
        d = data_bus_read;
    endtask

    initial begin
        logic [15:0] d;
        n_vec           = 0;
        n_miscmp        = 0;
        reset           = 1'b1;
        data_bus_write  = '0;
        data_bus_addr   = '0;
        data_bus_mode   = MODE_IDLE;
        data_bus_select = 1'b0;
        tb_en           = 16'hFFFF;
        tb_val          = 16'h0000;

        // 1: reset state
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_irq", irq, 0);
        for (int k = 0; k < 10; k++) begin
            rd(BASE + 32'(4 * k), d);
            check($sformatf("rst_reg%0d", k), d, 0);
        end
        tb_val = 16'h3C5A;
        #1;
        check("rst_pins_z", gpio_pins, 16'h3C5A);
        repeat (5) @(posedge clk);
        #1;
        rd(BASE + OFF_IN, d);
        check("rst_in_follow", d, 16'h3C5A);
        rd(BASE + OFF_IRQ_STATUS, d);
        check("rst_no_status", d, 0);

        // 2: direction, output and atomic set/clear/toggle
        tb_en  = 16'hFF00;
        tb_val = 16'h5A00;
        wrw(BASE + OFF_DIR, 16'h00FF);
        wrw(BASE + OFF_OUT, 16'hA5A5);
        check("pins_a5", gpio_pins, 16'h5AA5);
        wrw(BASE + OFF_OUT_SET, 16'h0002);
        wrw(BASE + OFF_OUT_CLR, 16'h0001);
        wrw(BASE + OFF_OUT_TGL, 16'h0080);
        rd(BASE + OFF_OUT, d);
        check("out_atomic", d, 16'hA526);
        check("pins_26", gpio_pins, 16'h5A26);
        repeat (4) @(posedge clk);
        #1;
        rd(BASE + OFF_IN, d);
        check("in_readback", d, 16'h5A26);

        // 3: rising edge on pin3, latency SYNC_DEPTH+1
        wrw(BASE + OFF_DIR, 16'h00F7);
        tb_en = 16'hFF08;
        wrw(BASE + OFF_IRQ_RISE, 16'h0008);
        wrw(BASE + OFF_IRQ_EN, 16'h0008);
        repeat (5) @(posedge clk);
        #1;
        peek(BASE + OFF_IRQ_STATUS, d);
        check("pre_rise_status", d, 0);
        tb_val[3] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rise_t3_irq", irq, 0);
        peek(BASE + OFF_IN, d);
        check("rise_t3_in", d, 16'h5A26);
        @(posedge clk);
        #1;
        check("rise_t4_irq", irq, 1);
        peek(BASE + OFF_IRQ_STATUS, d);
        check("rise_t4_status", d, 16'h0008);
        peek(BASE + OFF_IN, d);
        check("rise_t4_in", d, 16'h5A2E);
        tb_val[3] = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        peek(BASE + OFF_IRQ_STATUS, d);
        check("fall_ignored", d, 16'h0008);
        wrw(BASE + OFF_IRQ_EN, 16'h0000);
        check("masked_irq", irq, 0);
        peek(BASE + OFF_IRQ_STATUS, d);
        check("masked_status_kept", d, 16'h0008);
        wrw(BASE + OFF_IRQ_EN, 16'h0008);
        check("unmasked_irq", irq, 1);

        // 4: W1C, and clear coinciding with a new rise
        wrw(BASE + OFF_IRQ_STATUS, 16'h0008);
        check("w1c_irq", irq, 0);
        peek(BASE + OFF_IRQ_STATUS, d);
        check("w1c_status", d, 0);
        tb_val[3] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        wrw(BASE + OFF_IRQ_STATUS, 16'h0008);
        check("set_wins_irq", irq, 1);
        peek(BASE + OFF_IRQ_STATUS, d);
        check("set_wins_status", d, 16'h0008);
        wrw(BASE + OFF_IRQ_FALL, 16'h0008);
        wrw(BASE + OFF_IRQ_STATUS, 16'h0008);
        check("fall_pre_irq", irq, 0);
        tb_val[3] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("fall_irq", irq, 1);
        peek(BASE + OFF_IRQ_STATUS, d);
        check("fall_status", d, 16'h0008);

        // 5: dropped writes
        wr(BASE + 32'h28, 16'hFFFF, MODE_WRITE, 1'b1);
        wr(BASE + OFF_DIR, 16'hFFFF, MODE_WRITE, 1'b0);
        wr(BASE + OFF_DIR, 16'hFFFF, 2'b11, 1'b1);
        wr((BASE + OFF_OUT) | 32'h8000_0000, 16'hFFFF, MODE_WRITE, 1'b1);
        wr(BASE + OFF_IRQ_STATUS, 16'hFFFF, 2'b11, 1'b1);
        rd(BASE + OFF_DIR, d);
        check("drop_dir", d, 16'h00F7);
        rd(BASE + OFF_OUT, d);
        check("drop_out", d, 16'hA526);
        rd(BASE + OFF_IRQ_STATUS, d);
        check("drop_status", d, 16'h0008);
        rd(BASE + 32'h28, d);
        check("unmapped_rd", d, 0);
        rd(BASE + OFF_OUT_SET, d);
        check("wo_set_rd", d, 0);
        rd(BASE + OFF_OUT_TGL, d);
        check("wo_tgl_rd", d, 0);

        // 6: reset while outputs driven and irq pending
        tb_en = 16'h0000;
        wrw(BASE + OFF_DIR, 16'hFFFF);
        check("pre_rst_pins", gpio_pins, 16'hA526);
        check("pre_rst_irq", irq, 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset  = 1'b0;
        tb_en  = 16'hFFFF;
        tb_val = 16'h0000;
        check("mid_rst_irq", irq, 0);
        peek(BASE + OFF_IRQ_STATUS, d);
        check("mid_rst_status", d, 0);
        peek(BASE + OFF_DIR, d);
        check("mid_rst_dir", d, 0);
        for (int k = 0; k < 10; k++) begin
            rd(BASE + 32'(4 * k), d);
            check($sformatf("mid_rst_reg%0d", k), d, 0);
        end
        tb_val = 16'h3C5A;
        #1;
        check("mid_rst_pins_z", gpio_pins, 16'h3C5A);
        repeat (6) @(posedge clk);
        #1;
        rd(BASE + OFF_IN, d);
        check("post_rst_in", d, 16'h3C5A);
        rd(BASE + OFF_IRQ_STATUS, d);
        check("post_rst_status", d, 0);
        check("post_rst_irq", irq, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
